// File: rtl/clock_ctrl_if.sv
// Button inputs and pulse outputs between the clock sequencer and its neighbours.
// The master drives the raw buttons. The slave (clock_ctrl) drives the en/inc/dec/state pulses.
interface clock_ctrl_if;
  logic btn_inc;
  logic btn_dec;
  logic btn_state;
  logic en;
  logic inc;
  logic dec;
  logic state;

  modport master (output btn_inc, btn_dec, btn_state, input en, inc, dec, state);
  modport slave  (input btn_inc, btn_dec, btn_state, output en, inc, dec, state);
endinterface

// File: rtl/clock_ctrl.sv
// Input sequencer for the clock datapath. It synchronizes and debounces the pushbuttons,
// auto-repeats inc/dec, arbitrates single-cycle pulses and generates the 1 Hz en tick.
module clock_ctrl #(
  parameter int TICK_DIV     = 500,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
) (
  input  logic         clk,
  input  logic         reset,
  clock_ctrl_if.slave  io
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DBW  = $clog2(DEBOUNCE + 1);
  localparam int PW   = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

  // Bit order in every 3-bit vector: [0]=inc, [1]=dec, [2]=state.
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     lvl_q, lvl_d, lvl_prev_q;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];
  logic [2:0]     rise;
  logic           lock_q, lock_d, locked;

  rpt_state_e     rpt_q [2];
  logic [TW-1:0]  tmr_q [2];
  logic [1:0]     rreq_q;
  logic           sreq_q;

  logic [1:0]     pend_q, pend_d;
  logic           want_s, want_i, want_d;
  logic           en_q, en_d, inc_q, inc_d, dec_q, dec_d, state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;

  assign raw = {io.btn_state, io.btn_dec, io.btn_inc};

  // Debounce: the level flips after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE - 1)) lvl_d[i] = sync2_q[i];
        else                                   db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise   = lvl_q & ~lvl_prev_q;
  // Lockout latches while both inc and dec are down and holds until both are up.
  assign locked = (lvl_q[0] & lvl_q[1]) | lock_q;
  assign lock_d = (lvl_q[0] & lvl_q[1]) | (lock_q & (lvl_q[0] | lvl_q[1]));

  // Repeat FSMs for inc/dec. They issue registered one-cycle requests into the arbiter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rpt_q[i] <= IDLE;
        tmr_q[i] <= '0;
      end
      rreq_q <= '0;
      sreq_q <= 1'b0;
    end else begin
      sreq_q <= rise[2];
      for (int i = 0; i < 2; i++) begin
        rreq_q[i] <= 1'b0;
        if (locked || !lvl_q[i]) begin
          rpt_q[i] <= IDLE;
          tmr_q[i] <= '0;
        end else begin
          case (rpt_q[i])
            IDLE: begin
              if (rise[i]) begin
                rpt_q[i]  <= HOLD;
                tmr_q[i]  <= T_DELAY;
                rreq_q[i] <= 1'b1;
              end
            end
            HOLD, REPEAT: begin
              if (tmr_q[i] == T_ONE) begin
                rpt_q[i]  <= REPEAT;
                tmr_q[i]  <= T_RATE;
                rreq_q[i] <= 1'b1;
              end else begin
                tmr_q[i] <= tmr_q[i] - 1'b1;
              end
            end
            default: rpt_q[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Arbiter: state > inc > dec. A loser waits in its pending flag; repeat requests merge.
  always_comb begin
    want_s  = sreq_q;
    want_i  = (rreq_q[0] | pend_q[0]) & ~locked;
    want_d  = (rreq_q[1] | pend_q[1]) & ~locked;
    state_d = want_s;
    inc_d   = want_i & ~want_s;
    dec_d   = want_d & ~want_s & ~want_i;
    pend_d  = {want_d & ~dec_d, want_i & ~inc_d};
    en_d    = (pre_q == PW'(TICK_DIV - 1));
    if (state_d || en_d) pre_d = '0;
    else                 pre_d = pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      lock_q     <= 1'b0;
      pend_q     <= '0;
      pre_q      <= '0;
      en_q       <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      state_q    <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      lock_q     <= lock_d;
      pend_q     <= pend_d;
      pre_q      <= pre_d;
      en_q       <= en_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      state_q    <= state_d;
    end
  end

  assign io.en    = en_q;
  assign io.inc   = inc_q;
  assign io.dec   = dec_q;
  assign io.state = state_q;

endmodule
